fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline, directly upstream of hazard detection.
//   - Owns the PC and the IF/ID register.
//   - Fetches from a variable-latency instruction memory, one request outstanding at a time.
//   - Obeys the hazard-detection hold and the ID-stage branch flush.
//   - Inserts NOP bubbles into ID while memory is slow.
// PARAMETERS
//   PC_RESET   32'h0000_0000   PC value loaded on reset
// PORTS
//   clk_i             in   1   clock, all state updates on rising edge
//   rst_i             in   1   asynchronous reset, active-high
//   hold_i            in   1   1 = freeze PC and IF/ID (load-use stall from hazard detection)
//   flush_i           in   1   1 = branch taken in ID; redirect fetch, squash IF/ID
//   branch_target_i   in  32   redirect PC, sampled when flush_i=1
//   imem_req_o        out  1   fetch request valid
//   imem_addr_o       out 32   fetch address (= PC)
//   imem_ready_i      in   1   memory accepts request when imem_req_o & imem_ready_i
//   imem_rvalid_i     in   1   response valid, >=1 cycle after acceptance
//   imem_rdata_i      in  32   instruction word, valid with imem_rvalid_i
//   if_id_instr_o     out 32   IF/ID instruction (32'h0 = NOP when invalid)
//   if_id_pc4_o       out 32   IF/ID PC+4 of that instruction
//   if_id_valid_o     out  1   IF/ID holds a real instruction
// BEHAVIOUR
//   Reset (async, any state):
//   - PC <= PC_RESET; state <= FETCH.
//   - if_id_instr_o, if_id_pc4_o, if_id_valid_o <= 0.
//   - Memory is reset together with this block, so no stale response exists afterwards.
//   States:
//   - FETCH: imem_req_o=1, imem_addr_o=PC.
//     - Accept (req&ready) with hold_i=0, flush_i=0 -> WAIT.
//   - WAIT: imem_req_o=0; awaiting rvalid.
//   - HOLD: response captured in skid register; IF/ID frozen by hold_i.
//   - DROP: flushed while a request is outstanding; next rvalid is discarded.
//   Priority: hold_i over flush_i. flush_i is ignored while hold_i=1.
//   hold_i=1, all states:
//   - PC and IF/ID keep their values.
//   - An rvalid arriving in WAIT goes into the skid register; state -> HOLD.
//   - FETCH still issues; accepted -> WAIT.
//   hold_i=0, flush_i=0:
//   - WAIT + rvalid: IF/ID <= {rdata, PC+4, valid=1}; PC <= PC+4; -> FETCH.
//   - HOLD: IF/ID <= {skid, PC+4, valid=1}; PC <= PC+4; -> FETCH.
//   - Otherwise: IF/ID <= bubble {0, 0, valid=0}.
//   hold_i=0, flush_i=1:
//   - IF/ID <= bubble; PC <= branch_target_i.
//   - From WAIT without rvalid: -> DROP.
//   - From FETCH with req accepted this cycle: -> DROP.
//   - Otherwise (FETCH unaccepted, WAIT+rvalid, HOLD): -> FETCH, skid discarded.
//   - From DROP: stay in DROP.
//   DROP + rvalid: data discarded, IF/ID gets a bubble, PC unchanged; -> FETCH.
//   Request rules:
//   - A request is committed only on req&ready.
//   - Before acceptance, imem_addr_o may change (flush retarget).
//   Latency:
//   - Zero-wait memory (ready=1, rvalid one cycle after accept): one instruction
//     every 2 cycles, PC+4 sequence.
//   PC arithmetic: 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
//   Responses: rvalid outside WAIT/DROP is a protocol error; it is ignored.
// TESTING
//   1. Reset with PC_RESET=32'h100, ready=1, 1-cycle rvalid -> IF/ID shows
//      pc4 32'h104, 32'h108, ... with valid=1 every 2nd cycle, bubbles between.
//   2. hold_i=1 for 3 cycles while rvalid returns instr 32'h8C22_0004 ->
//      IF/ID unchanged for those 3 cycles; on release IF/ID=32'h8C22_0004, pc4 advances by 4.
//   3. flush_i=1, target 32'h200, while in WAIT -> late rvalid discarded,
//      next request addr 32'h200, no stale instruction enters IF/ID.
//   4. hold_i=1 and flush_i=1 same cycle -> flush ignored, PC unchanged;
//      flush reasserted after hold drops redirects to target.
//   5. imem_ready_i=0 for 5 cycles -> imem_addr_o stable, IF/ID bubbles (valid=0, instr=0).
//   6. PC=32'hFFFF_FFFC fetch -> if_id_pc4_o=32'h0, next addr 32'h0;
//      rst_i pulse mid-WAIT -> all outputs 0, PC=PC_RESET immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline.
//   Owns the PC and the IF/ID register. It fetches from a variable-latency
//   instruction memory with at most one request outstanding. It obeys the
//   hazard hold (hold_i) and the ID-stage branch flush (flush_i), and it feeds
//   NOP bubbles into ID while memory is slow.
// Ports:
//   clk_i, rst_i           clock; asynchronous active-high reset
//   hold_i                 freeze PC and IF/ID (load-use stall); wins over flush_i
//   flush_i                branch taken in ID: redirect to branch_target_i, squash IF/ID
//   branch_target_i        redirect PC
//   imem_req_o/addr_o      fetch request (address = PC)
//   imem_ready_i           request accepted on req & ready
//   imem_rvalid_i/rdata_i  response, at least one cycle after acceptance
//   if_id_instr_o/pc4_o    IF/ID instruction and its PC+4 (0/0 for a bubble)
//   if_id_valid_o          IF/ID holds a real instruction
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request driven at PC
    S_WAIT  = 2'd1,  // request accepted, awaiting rvalid
    S_HOLD  = 2'd2,  // response parked in skid while ID is stalled
    S_DROP  = 2'd3   // outstanding response belongs to a squashed path
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  if_id_t      if_id_q, if_id_d;

  logic        accept;
  logic [31:0] pc_plus4;

  assign accept   = (state_q == S_FETCH) && imem_ready_i;
  assign pc_plus4 = pc_q + 32'd4;  // wraps naturally at 2^32

  assign imem_req_o    = (state_q == S_FETCH);
  assign imem_addr_o   = pc_q;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign if_id_valid_o = if_id_q.valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skid_d  = skid_q;
    if_id_d = if_id_q;

    if (hold_i) begin
      // PC and IF/ID frozen; flush is ignored. Memory traffic keeps moving.
      unique case (state_q)
        S_FETCH: if (accept) state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid_i) begin
                   skid_d  = imem_rdata_i;
                   state_d = S_HOLD;
                 end
        S_HOLD:  ;
        S_DROP:  if (imem_rvalid_i) state_d = S_FETCH;  // stale data discarded
        default: state_d = S_FETCH;
      endcase
    end else if (flush_i) begin
      if_id_d = '0;
      pc_d    = branch_target_i;
      unique case (state_q)
        // An accepted request is in flight to the old path; its response must be dropped.
        S_FETCH: state_d = accept ? S_DROP : S_FETCH;
        S_WAIT:  state_d = imem_rvalid_i ? S_FETCH : S_DROP;
        S_HOLD:  state_d = S_FETCH;
        // The response arriving now is the doomed one, so nothing else is in flight.
        S_DROP:  state_d = imem_rvalid_i ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      if_id_d = '0;
      unique case (state_q)
        S_FETCH: if (accept) state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid_i) begin
                   if_id_d = '{instr: imem_rdata_i, pc4: pc_plus4, valid: 1'b1};
                   pc_d    = pc_plus4;
                   state_d = S_FETCH;
                 end
        S_HOLD:  begin
                   if_id_d = '{instr: skid_q, pc4: pc_plus4, valid: 1'b1};
                   pc_d    = pc_plus4;
                   state_d = S_FETCH;
                 end
        S_DROP:  if (imem_rvalid_i) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      skid_q  <= '0;
      if_id_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      if_id_q <= if_id_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0, flush = 1'b0;
  logic [31:0] tgt = '0;
  logic        req;
  logic [31:0] addr;
  logic        rdy = 1'b0, rv = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] id_instr, id_pc4;
  logic        id_v;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .branch_target_i(tgt), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ready_i(rdy), .imem_rvalid_i(rv), .imem_rdata_i(rdata),
    .if_id_instr_o(id_instr), .if_id_pc4_o(id_pc4), .if_id_valid_o(id_v)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_v);
    chk({tag, "_req"},   {31'd0, req},  {31'd0, e_req});
    chk({tag, "_addr"},  addr,          e_addr);
    chk({tag, "_instr"}, id_instr,      e_instr);
    chk({tag, "_pc4"},   id_pc4,        e_pc4);
    chk({tag, "_valid"}, {31'd0, id_v}, {31'd0, e_v});
  endtask

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic        h, f;
    logic [31:0] tg;
    logic        rd, rv;
    logic [31:0] rdat;
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_v;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic h, input logic f, input logic [31:0] tg,
                              input logic rd, input logic rvl, input logic [31:0] rdat,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_v);
    vec_t r;
    r.h = h; r.f = f; r.tg = tg; r.rd = rd; r.rv = rvl; r.rdat = rdat;
    r.e_req = e_req; r.e_addr = e_addr; r.e_instr = e_instr; r.e_pc4 = e_pc4; r.e_v = e_v;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Transaction view: list of outstanding requests (each tagged squashed or not)
  // and a list of responses parked while ID is stalled. A request may issue only
  // when both are empty.
  typedef struct packed { logic [31:0] a; logic sq; } out_t;
  typedef struct packed { logic [31:0] w; logic [31:0] a; } park_t;

  out_t        m_out[$];
  park_t       m_park[$];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_v;

  function automatic logic m_req();
    return (m_out.size() == 0) && (m_park.size() == 0);
  endfunction

  task automatic m_step(input logic h, input logic f, input logic [31:0] tg,
                        input logic rd, input logic rvl, input logic [31:0] rdat,
                        output logic acc);
    logic [31:0] old_pc;
    logic        resp;
    out_t        o;
    park_t       p;
    old_pc = m_pc;
    acc  = m_req() && rd;
    resp = rvl && (m_out.size() > 0);
    o = '0;
    if (resp) o = m_out.pop_front();
    if (h) begin
      if (resp && !o.sq) m_park.push_back('{w: rdat, a: o.a});
    end else if (f) begin
      m_instr = '0; m_pc4 = '0; m_v = 1'b0;
      m_pc = tg;
      foreach (m_out[i]) m_out[i].sq = 1'b1;
      m_park.delete();
    end else if (m_park.size() > 0) begin
      p = m_park.pop_front();
      m_instr = p.w; m_pc4 = p.a + 32'd4; m_v = 1'b1; m_pc = p.a + 32'd4;
    end else if (resp && !o.sq) begin
      m_instr = rdat; m_pc4 = o.a + 32'd4; m_v = 1'b1; m_pc = o.a + 32'd4;
    end else begin
      m_instr = '0; m_pc4 = '0; m_v = 1'b0;
    end
    if (acc) m_out.push_back('{a: old_pc, sq: (f && !h)});
  endtask

  initial begin
    logic        acc;
    logic        mem_busy;
    int          mem_cnt;
    logic        r_h, r_f, r_rd, r_rv;
    logic [31:0] r_tg, r_rdat;

    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h100,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h2401_0001,  1,32'h104,32'h2401_0001,32'h104,1));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h104,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h2402_0002,  1,32'h108,32'h2402_0002,32'h108,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h0,          0,32'h108,32'h2402_0002,32'h108,1));
    tbl.push_back(mk(1,0,32'h0,1,1,32'h8C22_0004,  0,32'h108,32'h2402_0002,32'h108,1));
    tbl.push_back(mk(1,1,32'h300,1,0,32'h0,        0,32'h108,32'h2402_0002,32'h108,1));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          1,32'h10C,32'h8C22_0004,32'h10C,1));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h10C,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,32'h200,1,0,32'h0,        0,32'h200,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'hDEAD_BEEF,  1,32'h200,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h200,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h2403_0003,  1,32'h204,32'h2403_0003,32'h204,1));
    tbl.push_back(mk(1,1,32'h400,0,0,32'h0,        1,32'h204,32'h2403_0003,32'h204,1));
    tbl.push_back(mk(0,1,32'h400,0,0,32'h0,        1,32'h400,32'h0,32'h0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,32'h0,0,0,32'h0,        1,32'h400,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h400,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h2404_0004,  1,32'h404,32'h2404_0004,32'h404,1));
    tbl.push_back(mk(0,1,32'h500,1,0,32'h0,        0,32'h500,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,0,1,32'hDEAD_BEEF,  1,32'h500,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'h500,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h2405_0005,  1,32'h504,32'h2405_0005,32'h504,1));
    tbl.push_back(mk(0,0,32'h0,0,1,32'hDEAD_BEEF,  1,32'h504,32'h0,32'h0,0));
    // PC wrap at the top of the address space
    tbl.push_back(mk(0,1,32'hFFFF_FFFC,0,0,32'h0,  1,32'hFFFF_FFFC,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,0,32'h0,          0,32'hFFFF_FFFC,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,1,1,32'h2406_0006,  1,32'h0,32'h2406_0006,32'h0,1));
    tbl.push_back(mk(1,0,32'h0,1,0,32'h0,          0,32'h0,32'h2406_0006,32'h0,1));

    repeat (3) @(negedge clk);
    chk_all("reset", 1'b1, RST_PC, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      hold = tbl[i].h; flush = tbl[i].f; tgt = tbl[i].tg;
      rdy = tbl[i].rd; rv = tbl[i].rv; rdata = tbl[i].rdat;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr,
              tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_v);
    end

    // Asynchronous reset mid-WAIT with a live IF/ID: effect must be immediate.
    @(negedge clk);
    hold = 1'b0; flush = 1'b0; rdy = 1'b0; rv = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 1'b1, RST_PC, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- randomized phase ----------------
    m_out.delete(); m_park.delete();
    m_pc = RST_PC; m_instr = '0; m_pc4 = '0; m_v = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
    @(posedge clk);  // idle edge after release: FETCH, bubble
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk_all($sformatf("rnd%0d", cyc), m_req(), m_pc, m_instr, m_pc4, m_v);
      r_h  = ($urandom_range(0, 9) < 2);
      r_f  = ($urandom_range(0, 9) < 1);
      r_tg = $urandom & 32'hFFFF_FFFC;
      r_rd = ($urandom_range(0, 9) < 7);
      r_rv = (mem_busy && mem_cnt == 0) || (!mem_busy && $urandom_range(0, 31) == 0);
      r_rdat = $urandom;
      hold = r_h; flush = r_f; tgt = r_tg; rdy = r_rd; rv = r_rv; rdata = r_rdat;
      m_step(r_h, r_f, r_tg, r_rd, r_rv, r_rdat, acc);
      if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (acc) begin
        mem_busy = 1'b1;
        mem_cnt  = $urandom_range(0, 3);
      end
    end

    @(negedge clk);
    chk_all("rnd_final", m_req(), m_pc, m_instr, m_pc4, m_v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
